conv3x3_window: RTL
===================

Name: conv3x3_window

Overview:
- Consumes the three row-aligned pixel streams from the 3-line buffer stage and builds a 3x3 sliding window.
- Applies a loadable signed 3x3 kernel to each complete window, then shifts and saturates the result back to pixel width.
- Emits one filtered pixel per complete window as a valid-qualified stream with fixed 3-cycle latency.
- Sits directly downstream of the line buffer; it has no backpressure.

Parameters:
- DATA_WIDTH, 16, unsigned pixel width.
- LENGTH, 100, pixels per line.
- COL_WIDTH, 7, column counter width; 2^COL_WIDTH >= LENGTH.
- COEF_WIDTH, 8, signed two's-complement coefficient width.
- SHIFT, 0, arithmetic right shift applied to the sum before saturation.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- row0_in  input  DATA_WIDTH  oldest line (top of window)
- row1_in  input  DATA_WIDTH  middle line
- row2_in  input  DATA_WIDTH  newest line (bottom of window)
- in_valid  input  1  all three rows valid this cycle
- coef  input  9*COEF_WIDTH  kernel; k[r][c] = coef[(3r+c)*COEF_WIDTH +: COEF_WIDTH], r=0 top, c=0 oldest column
- coef_load  input  1  latch coef into the kernel register
- data_out  output  DATA_WIDTH  filtered pixel
- out_valid  output  1  data_out valid this cycle

Behaviour:
- Clock/reset: single clock clk; reset is synchronous and active-low (rst_n sampled at posedge clk).
- Reset values:
  - data_out=0, out_valid=0, column counter=0, all window/pipeline registers and valid bits=0.
  - Kernel register = identity: k[1][1]=1, all other coefficients 0.
- Window:
  - Per row, a 2-deep shift register advances only on in_valid.
  - Window column 2 = current beat, column 1 = previous beat, column 0 = beat before that.
  - Idle cycles (in_valid=0) hold all shift registers and the counter.
- Column counter:
  - Increments on each in_valid beat and wraps LENGTH-1 -> 0.
  - A beat sampled with counter >= 2 is window-complete. Beats at counter 0 and 1 fill the window and produce no output.
  - Result: exactly LENGTH-2 outputs per line; no window spans two lines.
- Pipeline (no stall; advances every cycle, valid bit travels with data):
  - S1, at the sampling edge: nine products registered, pixel zero-extended to DATA_WIDTH+1 signed, times k. Product width DATA_WIDTH+COEF_WIDTH+1.
  - S2: three per-row sums registered, width +2 bits.
  - S3: total sum (ACC width DATA_WIDTH+COEF_WIDTH+5), arithmetic shift right by SHIFT, saturated to [0, 2^DATA_WIDTH-1], registered into data_out/out_valid.
  - Latency: beat sampled at edge E0 -> result on data_out with out_valid=1 after edge E3.
- Outputs when no result: out_valid=0 and data_out holds its last value.
- Kernel load:
  - Kernel register updates at the edge where coef_load=1.
  - A beat sampled at that same edge uses the old kernel; later beats use the new kernel.
  - In-flight results are never altered.
- Simultaneous events: coef_load with in_valid is legal, per the rule above. rst_n=0 overrides everything.
- Reset mid-line: the next cycle has out_valid=0, counter=0 and kernel=identity. In-flight results are discarded, and the next beat is treated as column 0.
- Overflow: impossible within ACC width. Negative sums clamp to 0; sums above max clamp to 2^DATA_WIDTH-1.

Test Plan:
- Identity after reset:
  - Stimulus: row1 pixel = column index, row0=row2=0xAAAA, 100 back-to-back beats.
  - Required: 98 outputs with values 1..98, first out_valid 3 cycles after the column-2 beat.
- Box kernel:
  - Stimulus: coef_load with all k=1, all pixels 10.
  - Required: every output 90. The beat sampled on the coef_load edge still uses identity and outputs 10.
- Saturation:
  - All k=1 with all pixels 0xFFFF -> 0xFFFF.
  - k[1][1]=-1, others 0, pixels 5 -> 0.
  - SHIFT=3 build, all k=1, pixels 8 -> 9.
- Bubbles:
  - Stimulus: the identity ramp with random in_valid gaps (up to 5 idle cycles).
  - Required: identical output sequence 1..98, and out_valid never asserted more than 3 cycles after its source beat.
- Line wrap:
  - Stimulus: two consecutive lines of 100 beats each.
  - Required: no out_valid for columns 0 and 1 of line 2; 196 outputs in total.
- Reset mid-line:
  - Stimulus: assert rst_n=0 for 1 cycle at column 50 with results in flight.
  - Required: out_valid=0 from the next cycle, no stale results, kernel back to identity. A fresh line then yields 98 outputs.

Source files
------------

// File: rtl/conv3x3_window.sv
// 3x3 sliding-window convolution over three row-aligned pixel streams.
// A loadable signed kernel is applied to each complete window. The sum is
// shifted and saturated to pixel width, and one pixel is emitted per window
// with a fixed latency.
module conv3x3_window #(
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 100,
  parameter int COL_WIDTH  = 7,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   row0_in,
  input  logic [DATA_WIDTH-1:0]   row1_in,
  input  logic [DATA_WIDTH-1:0]   row2_in,
  input  logic                    in_valid,
  input  logic [9*COEF_WIDTH-1:0] coef,
  input  logic                    coef_load,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    out_valid
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;  // product width
  localparam int RW = PW + 2;                       // per-row sum width
  localparam int AW = DATA_WIDTH + COEF_WIDTH + 5;  // accumulator width
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(LENGTH - 1);
  localparam logic signed [AW-1:0] MAX_PIX  = AW'({DATA_WIDTH{1'b1}});

  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  coef_t                  k      [9];
  logic [DATA_WIDTH-1:0]  rows   [3];
  logic [DATA_WIDTH-1:0]  col1   [3];
  logic [DATA_WIDTH-1:0]  col0   [3];
  logic [DATA_WIDTH-1:0]  pix    [9];
  logic [COL_WIDTH-1:0]   col_cnt;
  logic signed [PW-1:0]   prod_c [9];
  logic signed [PW-1:0]   prod_q [9];
  logic signed [RW-1:0]   rsum_q [3];
  logic signed [AW-1:0]   total_q;
  logic signed [AW-1:0]   shifted;
  logic [DATA_WIDTH-1:0]  sat;
  logic                   v1, v2, v3;

  assign rows[0] = row0_in;
  assign rows[1] = row1_in;
  assign rows[2] = row2_in;

  // Kernel register: identity after reset, reloaded on coef_load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 9; i++) k[i] <= (i == 4) ? coef_t'(1) : '0;
    end else if (coef_load) begin
      for (int unsigned i = 0; i < 9; i++) k[i] <= coef[i*COEF_WIDTH +: COEF_WIDTH];
    end
  end

  // Per-row 2-deep shift registers and column counter, advancing on beats only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++) begin
        col1[r] <= '0;
        col0[r] <= '0;
      end
      col_cnt <= '0;
    end else if (in_valid) begin
      for (int unsigned r = 0; r < 3; r++) begin
        col0[r] <= col1[r];
        col1[r] <= rows[r];
      end
      col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
    end
  end

  // Window taps (index 3r+c) and their signed products with the current kernel.
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      pix[3*r]     = col0[r];
      pix[3*r + 1] = col1[r];
      pix[3*r + 2] = rows[r];
    end
    for (int unsigned i = 0; i < 9; i++) begin
      prod_c[i] = PW'(signed'({1'b0, pix[i]})) * PW'(k[i]);
    end
  end

  // Shift and clamp the total into [0, 2^DATA_WIDTH-1].
  always_comb begin
    shifted = total_q >>> SHIFT;
    if (shifted[AW-1])          sat = '0;
    else if (shifted > MAX_PIX) sat = '1;
    else                        sat = shifted[DATA_WIDTH-1:0];
  end

  // Free-running pipeline: products, row sums, total, then saturated output.
  // The total is registered separately from the saturation so the result of a
  // beat sampled at edge E0 appears after E3 while products still use the
  // kernel in force at E0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 9; i++) prod_q[i] <= '0;
      for (int unsigned r = 0; r < 3; r++) rsum_q[r] <= '0;
      total_q   <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      v1 <= in_valid && (col_cnt >= COL_WIDTH'(2));
      for (int unsigned i = 0; i < 9; i++) prod_q[i] <= prod_c[i];
      v2 <= v1;
      for (int unsigned r = 0; r < 3; r++) begin
        rsum_q[r] <= RW'(prod_q[3*r]) + RW'(prod_q[3*r + 1]) + RW'(prod_q[3*r + 2]);
      end
      v3      <= v2;
      total_q <= AW'(rsum_q[0]) + AW'(rsum_q[1]) + AW'(rsum_q[2]);
      out_valid <= v3;
      if (v3) data_out <= sat;
    end
  end

endmodule
